// File: rtl/word_packer.sv
// word_packer
//
// Width up-converter between two read/write-enable buffer stages. Consecutive
// WIDTH-bit words are popped from an upstream buffer and packed, first word in
// the least significant lane, into RATIO*WIDTH-bit words. Each packed word is
// pushed into a downstream buffer together with a count of its valid lanes. A
// flush request emits a partially filled word without waiting for RATIO words.
//
// Ports:
//   clock             single clock, all state updates on its rising edge
//   reset             synchronous, active-high
//   empty             upstream buffer has no data
//   read_enable       pop one word from upstream this cycle
//   read_data         upstream head word, sampled when read_enable=1
//   full              downstream buffer cannot accept a write
//   write_enable      push write_data/write_count downstream this cycle
//   write_data        packed word, first received word in bits [WIDTH-1:0]
//   write_count       number of valid lanes in write_data (1..RATIO)
//   flush             level request to emit the partial accumulator
//   flush_acknowledge flush honoured at this rising edge

module word_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         empty,
    output logic                         read_enable,
    input  logic [WIDTH-1:0]             read_data,
    input  logic                         full,
    output logic                         write_enable,
    output logic [RATIO*WIDTH-1:0]       write_data,
    output logic [$clog2(RATIO+1)-1:0]   write_count,
    input  logic                         flush,
    output logic                         flush_acknowledge
);

    localparam int CW = $clog2(RATIO + 1);
    localparam int LW = $clog2(RATIO);
    localparam int AW = (RATIO - 1) * WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [LW-1:0]          fill;
    logic [LW-1:0]          fill_next;
    logic [AW-1:0]          acc;
    logic [AW-1:0]          acc_next;
    logic [RATIO*WIDTH-1:0] out_data;
    logic [RATIO*WIDTH-1:0] out_data_next;
    logic [CW-1:0]          out_count;
    logic [CW-1:0]          out_count_next;
    logic                   out_valid;
    logic                   out_valid_next;

    logic                   slot_free;
    logic                   load;
    logic [CW-1:0]          cand_count;
    logic [RATIO*WIDTH-1:0] cand_data;

    // Handshake outputs. The output register is free when it is empty or is
    // being drained this cycle, so a new word may land in it at the same edge.
    // Reset forces every enable low even before the first clock edge.
    always_comb begin
        slot_free         = !out_valid || !full;
        read_enable       = !reset && !empty && ((fill != LAST_LANE) || slot_free);
        write_enable      = !reset && out_valid && !full;
        flush_acknowledge = !reset && flush && slot_free;
        write_data        = out_data;
        write_count       = out_count;
    end

    // Candidate word: the accumulated lanes plus any word read at this edge.
    // Accumulator lanes at or above fill are always zero, so placing the
    // incoming word at lane fill on top of the zero-extended accumulator gives
    // the packed word with its upper lanes already cleared.
    always_comb begin
        cand_count = CW'(fill) + CW'(read_enable);
        cand_data  = {{WIDTH{1'b0}}, acc};
        if (read_enable) begin
            cand_data[int'(fill)*WIDTH +: WIDTH] = read_data;
        end
        load = (read_enable && (fill == LAST_LANE)) ||
               (flush_acknowledge && (cand_count != '0));
    end

    // Next-state logic. A load (full pack or non-empty flush) moves the
    // candidate into the output register and clears the accumulator; an
    // empty flush falls through and changes nothing. Without a load, a read
    // stores the word in the next free lane and a completed write empties
    // the output register.
    always_comb begin
        fill_next      = fill;
        acc_next       = acc;
        out_data_next  = out_data;
        out_count_next = out_count;
        out_valid_next = out_valid;

        if (load) begin
            fill_next      = '0;
            acc_next       = '0;
            out_data_next  = cand_data;
            out_count_next = cand_count;
            out_valid_next = 1'b1;
        end else begin
            if (read_enable) begin
                acc_next[int'(fill)*WIDTH +: WIDTH] = read_data;
                fill_next = fill + LW'(1);
            end
            if (write_enable) begin
                out_valid_next = 1'b0;
            end
        end
    end

    // State registers; reset discards both partial and pending data.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill      <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            fill      <= fill_next;
            acc       <= acc_next;
            out_data  <= out_data_next;
            out_count <= out_count_next;
            out_valid <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer
//
// Directed self-checking bench for word_packer with WIDTH=8, RATIO=4.
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising edge at which the design updates.

module tb_word_packer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic                     clock;
    logic                     reset;
    logic                     empty;
    logic                     read_enable;
    logic [WIDTH-1:0]         read_data;
    logic                     full;
    logic                     write_enable;
    logic [RATIO*WIDTH-1:0]   write_data;
    logic [$clog2(RATIO+1)-1:0] write_count;
    logic                     flush;
    logic                     flush_acknowledge;

    int checks = 0;
    int errors = 0;
    int accepted;

    word_packer #(
        .WIDTH(WIDTH),
        .RATIO(RATIO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .empty             (empty),
        .read_enable       (read_enable),
        .read_data         (read_data),
        .full              (full),
        .write_enable      (write_enable),
        .write_data        (write_data),
        .write_count       (write_count),
        .flush             (flush),
        .flush_acknowledge (flush_acknowledge)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs at the falling edge and let them settle.
    task automatic applyStimulus(input logic rst, input logic emp,
                                 input logic [WIDTH-1:0] data,
                                 input logic fl, input logic fu);
        @(negedge clock);
        reset     = rst;
        empty     = emp;
        read_data = data;
        flush     = fl;
        full      = fu;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence covering reset, packing, backpressure, flush
    // and mid-operation reset.
    initial begin
        reset = 1'b1; empty = 1'b0; read_data = 8'h55; flush = 1'b1; full = 1'b0;

        // Reset held with data and flush offered: everything must stay low.
        applyStimulus(1, 0, 8'h55, 1, 0);
        checkOutput("rst_re", read_enable, 0);
        checkOutput("rst_we", write_enable, 0);
        checkOutput("rst_fa", flush_acknowledge, 0);
        applyStimulus(1, 0, 8'h55, 1, 0);

        // Idle after reset.
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("idle_re", read_enable, 0);
        checkOutput("idle_we", write_enable, 0);
        checkOutput("idle_fa", flush_acknowledge, 0);

        // Four words packed into one.
        applyStimulus(0, 0, 8'h11, 0, 0);
        checkOutput("p4_re0", read_enable, 1);
        checkOutput("p4_we0", write_enable, 0);
        applyStimulus(0, 0, 8'h22, 0, 0);
        checkOutput("p4_re1", read_enable, 1);
        applyStimulus(0, 0, 8'h33, 0, 0);
        checkOutput("p4_re2", read_enable, 1);
        applyStimulus(0, 0, 8'h44, 0, 0);
        checkOutput("p4_re3", read_enable, 1);
        checkOutput("p4_we3", write_enable, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("p4_we", write_enable, 1);
        checkOutput("p4_wd", write_data, 64'h44332211);
        checkOutput("p4_wc", write_count, 4);
        checkOutput("p4_re_empty", read_enable, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("p4_we_once", write_enable, 0);

        // Continuous stream 0x00..0x0F at one word per cycle.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, 8'(k), 0, 0);
            checkOutput($sformatf("st_re%0d", k), read_enable, 1);
            if (k != 0 && (k % 4) == 0) begin
                checkOutput($sformatf("st_we%0d", k), write_enable, 1);
                checkOutput($sformatf("st_wd%0d", k), write_data,
                            {32'h0, 8'(k - 1), 8'(k - 2), 8'(k - 3), 8'(k - 4)});
            end else begin
                checkOutput($sformatf("st_we%0d", k), write_enable, 0);
            end
        end
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("st_we_last", write_enable, 1);
        checkOutput("st_wd_last", write_data, 64'h0F0E0D0C);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("st_drained", write_enable, 0);

        // Downstream full: the register and three lanes fill, then stall.
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 8'(accepted), 0, 1);
            checkOutput($sformatf("bp_we%0d", c), write_enable, 0);
            if (read_enable) accepted++;
        end
        checkOutput("bp_accepted", 64'(accepted), 7);
        checkOutput("bp_re_stall", read_enable, 0);

        // Release: pending word drains and reading resumes in the same cycle.
        applyStimulus(0, 0, 8'h07, 0, 0);
        checkOutput("rel_we", write_enable, 1);
        checkOutput("rel_wd", write_data, 64'h03020100);
        checkOutput("rel_re", read_enable, 1);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("rel_we2", write_enable, 1);
        checkOutput("rel_wd2", write_data, 64'h07060504);
        checkOutput("rel_wc2", write_count, 4);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("rel_drained", write_enable, 0);

        // Flush of a two-word partial.
        applyStimulus(0, 0, 8'hAA, 0, 0);
        checkOutput("fl_re0", read_enable, 1);
        applyStimulus(0, 0, 8'hBB, 0, 0);
        checkOutput("fl_re1", read_enable, 1);
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("fl_fa", flush_acknowledge, 1);
        checkOutput("fl_we_pre", write_enable, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("fl_we", write_enable, 1);
        checkOutput("fl_wd", write_data, 64'h0000BBAA);
        checkOutput("fl_wc", write_count, 2);

        // Flush with nothing accumulated: acknowledged, no write follows.
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("fl0_fa", flush_acknowledge, 1);
        checkOutput("fl0_we", write_enable, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("fl0_no_write", write_enable, 0);

        // Flush coinciding with a read: the read word joins the partial.
        applyStimulus(0, 0, 8'h01, 0, 0);
        checkOutput("flr_re0", read_enable, 1);
        applyStimulus(0, 0, 8'h02, 1, 0);
        checkOutput("flr_re1", read_enable, 1);
        checkOutput("flr_fa", flush_acknowledge, 1);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("flr_we", write_enable, 1);
        checkOutput("flr_wd", write_data, 64'h00000201);
        checkOutput("flr_wc", write_count, 2);

        // Flush blocked while the output register is held by a full buffer.
        applyStimulus(0, 0, 8'h61, 0, 0);
        applyStimulus(0, 0, 8'h62, 0, 0);
        applyStimulus(0, 0, 8'h63, 0, 0);
        applyStimulus(0, 0, 8'h64, 0, 0);
        applyStimulus(0, 0, 8'h65, 1, 1);
        checkOutput("flb_fa", flush_acknowledge, 0);
        checkOutput("flb_re", read_enable, 1);
        applyStimulus(0, 1, 8'h00, 1, 1);
        checkOutput("flb_fa2", flush_acknowledge, 0);
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("flb_fa3", flush_acknowledge, 1);
        checkOutput("flb_wd", write_data, 64'h64636261);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("flb_wd2", write_data, 64'h00000065);
        checkOutput("flb_wc2", write_count, 1);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("flb_drained", write_enable, 0);

        // Reset mid-accumulation discards the partial word.
        applyStimulus(0, 0, 8'h01, 0, 0);
        applyStimulus(0, 0, 8'h02, 0, 0);
        applyStimulus(0, 0, 8'h03, 0, 0);
        applyStimulus(1, 0, 8'h04, 0, 0);
        checkOutput("mr_re", read_enable, 0);
        checkOutput("mr_we", write_enable, 0);
        applyStimulus(0, 0, 8'h10, 0, 0);
        checkOutput("mr_re0", read_enable, 1);
        applyStimulus(0, 0, 8'h11, 0, 0);
        applyStimulus(0, 0, 8'h12, 0, 0);
        checkOutput("mr_we_early", write_enable, 0);
        applyStimulus(0, 0, 8'h13, 0, 0);
        checkOutput("mr_we_pre", write_enable, 0);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("mr_we", write_enable, 1);
        checkOutput("mr_wd", write_data, 64'h13121110);
        checkOutput("mr_wc", write_count, 4);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("mr_single", write_enable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
